// File: rtl/spi_sd_target_pkg.sv
// Shared constants, state encodings and the command decoder for the SPI-mode SD target.
package spi_sd_target_pkg;

  localparam logic [5:0] CMD_GO_IDLE     = 6'd0;
  localparam logic [5:0] CMD_READ_SINGLE = 6'd17;
  localparam logic [5:0] CMD_APP_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP_CMD     = 6'd55;

  localparam logic [7:0] R1_IDLE     = 8'h01;
  localparam logic [7:0] R1_ILLEGAL  = 8'h04;
  localparam logic [7:0] R1_PARAM    = 8'h40;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;

  localparam logic [2:0] ST_HUNT  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_NCR   = 3'd2;
  localparam logic [2:0] ST_R1    = 3'd3;
  localparam logic [2:0] ST_TOKEN = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;
  localparam logic [2:0] ST_CRC   = 3'd6;

  typedef struct packed {
    logic [7:0] r1;
    logic       idle;  // card_idle after this command
    logic       app;   // app_pending after this command
    logic       go;    // a data block follows R1
  } sd_resp_t;

  function automatic sd_resp_t sd_decode(input logic [5:0] idx, input logic [31:0] arg,
                                         input logic idle, input logic app,
                                         input logic [31:0] nblocks);
    sd_resp_t r;
    r.idle = idle;
    r.app  = (idx == CMD_APP_CMD);
    r.go   = 1'b0;
    r.r1   = R1_ILLEGAL | {7'b0, idle};
    case (idx)
      CMD_GO_IDLE: begin
        r.idle = 1'b1;
        r.r1   = R1_IDLE;
      end
      CMD_APP_CMD: r.r1 = {7'b0, idle};
      CMD_APP_OP_COND: if (app) begin
        r.idle = 1'b0;
        r.r1   = 8'h00;
      end
      CMD_READ_SINGLE: begin
        if (idle)              r.r1 = R1_ILLEGAL | R1_IDLE;
        else if (arg >= nblocks) r.r1 = R1_PARAM;
        else begin
          r.r1 = 8'h00;
          r.go = 1'b1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sd_target_if.sv
// SPI link plus backing-memory port of the SD target; slave = the target, master = host/memory side.
interface spi_sd_target_if #(parameter int MEM_AW = 14);
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              card_idle;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, mem_rdata,
    output spi_miso, spi_miso_oe, mem_addr, mem_rd, card_idle
  );
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, mem_rdata,
    input  spi_miso, spi_miso_oe, mem_addr, mem_rd, card_idle
  );
endinterface

// File: rtl/spi_sd_target_edge_sync.sv
// Synchronizes sck/cs_n/mosi into clk and flags sck edges; all three share the same depth so they stay aligned.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_n_sync,
  output logic mosi_sync
);
  logic [SYNC_STAGES-1:0] sck_ff, cs_ff, mosi_ff;
  logic                   sck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_ff  <= '0;
      cs_ff   <= '1;
      mosi_ff <= '1;
      sck_q   <= 1'b0;
    end else begin
      sck_ff[0]  <= sck;
      cs_ff[0]   <= cs_n;
      mosi_ff[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_ff[i]  <= sck_ff[i-1];
        cs_ff[i]   <= cs_ff[i-1];
        mosi_ff[i] <= mosi_ff[i-1];
      end
      sck_q <= sck_ff[SYNC_STAGES-1];
    end
  end

  assign sck_rise  =  sck_ff[SYNC_STAGES-1] & ~sck_q;
  assign sck_fall  = ~sck_ff[SYNC_STAGES-1] &  sck_q;
  assign cs_n_sync = cs_ff[SYNC_STAGES-1];
  assign mosi_sync = mosi_ff[SYNC_STAGES-1];
endmodule

// File: rtl/spi_sd_target.sv
// SPI-mode SD card responder: decodes 6-byte commands, answers R1, serves CMD17 blocks from byte memory.
module spi_sd_target
  import spi_sd_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW      = 14,
  parameter int NCR_BYTES   = 1
) (
  input logic            clk,
  input logic            reset,
  spi_sd_target_if.slave bus
);
  localparam logic [31:0] NBLOCKS = 32'(1) << (MEM_AW - 9);

  logic sck_rise, sck_fall, cs_n_s, mosi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sck       (bus.spi_sck),
    .cs_n      (bus.spi_cs_n),
    .mosi      (bus.spi_mosi),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_n_sync (cs_n_s),
    .mosi_sync (mosi_s)
  );

  logic [2:0]        state;
  logic [46:0]       rx_sr;
  logic [47:0]       rx_word;
  logic [5:0]        bit_cnt;
  logic [8:0]        byte_cnt;
  logic [7:0]        tx_sr, r1_q;
  logic [MEM_AW-10:0] blk_q;
  logic              go_q, app_pending, card_idle_q, miso_q, mem_rd_q, rd_pend;
  sd_resp_t          resp;
  logic              unused_frame;

  // Frame as it stands once the current rise's bit is included.
  assign rx_word      = {rx_sr, mosi_s};
  assign resp         = sd_decode(rx_word[45:40], rx_word[39:8], card_idle_q, app_pending, NBLOCKS);
  assign unused_frame = ^{rx_word[47:46], rx_word[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_HUNT;
      rx_sr       <= '1;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      tx_sr       <= FILL_BYTE;
      r1_q        <= FILL_BYTE;
      blk_q       <= '0;
      go_q        <= 1'b0;
      app_pending <= 1'b0;
      card_idle_q <= 1'b1;
      miso_q      <= 1'b1;
      mem_rd_q    <= 1'b0;
      rd_pend     <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      rd_pend  <= mem_rd_q;
      if (rd_pend) tx_sr <= bus.mem_rdata;
      if (cs_n_s) begin
        // Deselect aborts anything in flight; any coincident sck edge is dropped.
        state    <= ST_HUNT;
        rx_sr    <= '1;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        tx_sr    <= FILL_BYTE;
        miso_q   <= 1'b1;
        rd_pend  <= 1'b0;
      end else if (sck_rise) begin
        case (state)
          ST_HUNT: begin
            rx_sr <= rx_word[46:0];
            if (!rx_sr[0] && mosi_s) begin
              state   <= ST_CMD;
              bit_cnt <= 6'd2;
            end
          end
          ST_CMD: begin
            if (bit_cnt == 6'd47) begin
              state       <= ST_NCR;
              bit_cnt     <= '0;
              byte_cnt    <= '0;
              tx_sr       <= FILL_BYTE;
              rx_sr       <= '1;
              r1_q        <= resp.r1;
              card_idle_q <= resp.idle;
              app_pending <= resp.app;
              go_q        <= resp.go;
              blk_q       <= rx_word[8 +: MEM_AW-9];
            end else begin
              rx_sr   <= rx_word[46:0];
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          default: begin
            if (bit_cnt == 6'd7) begin
              // 8th rise of a tx byte: queue the next byte for the coming fall.
              bit_cnt <= '0;
              case (state)
                ST_NCR: begin
                  if (byte_cnt == 9'(NCR_BYTES - 1)) begin
                    state    <= ST_R1;
                    tx_sr    <= r1_q;
                    byte_cnt <= '0;
                  end else begin
                    byte_cnt <= byte_cnt + 9'd1;
                    tx_sr    <= FILL_BYTE;
                  end
                end
                ST_R1: begin
                  state <= go_q ? ST_TOKEN : ST_HUNT;
                  tx_sr <= go_q ? START_TOKEN : FILL_BYTE;
                end
                ST_TOKEN: begin
                  state    <= ST_DATA;
                  byte_cnt <= '0;
                  mem_rd_q <= 1'b1;
                end
                ST_DATA: begin
                  byte_cnt <= byte_cnt + 9'd1;
                  if (byte_cnt == 9'd511) begin
                    state <= ST_CRC;
                    tx_sr <= FILL_BYTE;
                  end else begin
                    mem_rd_q <= 1'b1;
                  end
                end
                default: begin
                  tx_sr <= FILL_BYTE;
                  if (byte_cnt == 9'd1) begin
                    state    <= ST_HUNT;
                    byte_cnt <= '0;
                  end else begin
                    byte_cnt <= 9'd1;
                  end
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        endcase
      end else if (sck_fall) begin
        miso_q <= tx_sr[7];
        tx_sr  <= {tx_sr[6:0], 1'b1};
      end
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = ~cs_n_s;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = {blk_q, byte_cnt};
  assign bus.card_idle   = card_idle_q;
endmodule
